// File: rtl/qbus_pkg.sv
// Shared definitions for the Q-bus RAM bridge: FSM states, window geometry and lane decode.
package qbus_pkg;

    localparam int unsigned WIN_BITS = 11;
    localparam int unsigned RAM_AW   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StRd,
        StWr,
        StReply,
        StSkip
    } qbus_state_e;

    // Byte data stays on its own lane of the bus; only the lane enables change.
    function automatic logic [1:0] lane_sel(input logic wtbt, input logic a0);
        if (!wtbt) begin
            return 2'b11;
        end else if (!a0) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

endpackage

// File: rtl/qbus_ram_bridge.sv
// Q-bus slave mapping a 2 KB window onto a 1K x 16 synchronous RAM; all outputs registered.
module qbus_ram_bridge
    import qbus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       ad_in,
    input  logic              sync,
    input  logic              din,
    input  logic              dout,
    input  logic              wtbt,
    output logic [15:0]       ad_out,
    output logic              ad_oe,
    output logic              rply,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [1:0]        ram_sel,
    output logic [15:0]       ram_di,
    output logic              ram_wr,
    input  logic [15:0]       ram_do
);

    qbus_state_e state_q;
    logic        sync_q;
    logic        a0_q;
    logic        rd_cyc_q;
    logic        in_win;
    logic        strobe_low;

    assign in_win     = (ad_in[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
    assign strobe_low = rd_cyc_q ? !din : !dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            // Held high so a SYNC already asserted across reset is not seen as a rise.
            sync_q   <= 1'b1;
            a0_q     <= 1'b0;
            rd_cyc_q <= 1'b0;
            ad_out   <= '0;
            ad_oe    <= 1'b0;
            rply     <= 1'b0;
            ram_addr <= '0;
            ram_sel  <= '0;
            ram_di   <= '0;
            ram_wr   <= 1'b0;
        end else begin
            sync_q <= sync;
            unique case (state_q)
                StIdle: begin
                    if (sync && !sync_q) begin
                        if (in_win) begin
                            ram_addr <= ad_in[RAM_AW:1];
                            a0_q     <= ad_in[0];
                            state_q  <= StSel;
                        end else begin
                            state_q <= StSkip;
                        end
                    end
                end
                StSkip: begin
                    if (!sync) begin
                        state_q <= StIdle;
                    end
                end
                StSel: begin
                    if (!sync) begin
                        state_q <= StIdle;
                    end else if (din) begin
                        rd_cyc_q <= 1'b1;
                        state_q  <= StRd;
                    end else if (dout) begin
                        rd_cyc_q <= 1'b0;
                        ram_di   <= ad_in;
                        ram_sel  <= lane_sel(wtbt, a0_q);
                        ram_wr   <= 1'b1;
                        state_q  <= StWr;
                    end
                end
                StRd: begin
                    if (!sync) begin
                        state_q <= StIdle;
                    end else begin
                        ad_out  <= ram_do;
                        ad_oe   <= 1'b1;
                        rply    <= 1'b1;
                        state_q <= StReply;
                    end
                end
                StWr: begin
                    // The write strobe always drops here, even when the cycle is aborted.
                    ram_wr <= 1'b0;
                    if (!sync) begin
                        state_q <= StIdle;
                    end else begin
                        rply    <= 1'b1;
                        state_q <= StReply;
                    end
                end
                StReply: begin
                    if (!sync) begin
                        rply    <= 1'b0;
                        ad_oe   <= 1'b0;
                        state_q <= StIdle;
                    end else if (strobe_low) begin
                        rply    <= 1'b0;
                        ad_oe   <= 1'b0;
                        state_q <= StSel;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qbus_ram_bridge.sv
// Directed bench for qbus_ram_bridge: per-cycle vector table plus reset corner sequences.
module tb_qbus_ram_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] ad_in;
    logic        sync, din, dout, wtbt;
    logic [15:0] ad_out;
    logic        ad_oe, rply;
    logic [9:0]  ram_addr;
    logic [1:0]  ram_sel;
    logic [15:0] ram_di;
    logic        ram_wr;
    logic [15:0] ram_do;

    logic [15:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sy, dn, dt, wt;
        logic [15:0] ad;
        logic        rp, oe, wr;
        logic [3:0]  cm;
        logic [9:0]  ea;
        logic [1:0]  es;
        logic [15:0] ed, eo;
    } vec_t;

    vec_t vq[$];

    localparam logic [3:0] MA = 4'b1000, MS = 4'b0100, MD = 4'b0010, MO = 4'b0001;

    qbus_ram_bridge #(.BASE_ADDR(16'h0000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ad_in    (ad_in),
        .sync     (sync),
        .din      (din),
        .dout     (dout),
        .wtbt     (wtbt),
        .ad_out   (ad_out),
        .ad_oe    (ad_oe),
        .rply     (rply),
        .ram_addr (ram_addr),
        .ram_sel  (ram_sel),
        .ram_di   (ram_di),
        .ram_wr   (ram_wr),
        .ram_do   (ram_do)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: read data valid one clock after the address.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            ram_do <= 16'h0000;
        end else begin
            if (ram_wr) begin
                if (ram_sel[0]) mem[ram_addr][7:0]  <= ram_di[7:0];
                if (ram_sel[1]) mem[ram_addr][15:8] <= ram_di[15:8];
            end
            ram_do <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic add(input logic sy, dn, dt, wt, input logic [15:0] ad,
                       input logic rp, oe, wr, input logic [3:0] cm,
                       input logic [9:0] ea, input logic [1:0] es,
                       input logic [15:0] ed, eo);
        vec_t v;
        v.sy = sy; v.dn = dn; v.dt = dt; v.wt = wt; v.ad = ad;
        v.rp = rp; v.oe = oe; v.wr = wr; v.cm = cm;
        v.ea = ea; v.es = es; v.ed = ed; v.eo = eo;
        vq.push_back(v);
    endtask

    task automatic drive(input logic sy, dn, dt, wt, input logic [15:0] ad);
        sync = sy; din = dn; dout = dt; wtbt = wt; ad_in = ad;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Word write then read at 0x0010 (word 8).
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0010, 0,0,0, MA,      8,  0, 0, 0);
        add(1,0,1,0,16'h1234, 0,0,1, MA|MS|MD,8,  3, 16'h1234, 0);
        add(1,0,1,0,16'h1234, 1,0,0, 0,       0,  0, 0, 0);
        add(1,0,1,0,16'h1234, 1,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0010, 0,0,0, MA,      8,  0, 0, 0);
        add(1,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 1,1,0, MO,      0,  0, 0, 16'h1234);
        add(1,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // Byte writes: high byte at odd address, low byte at even, read back.
        add(1,0,0,0,16'h0011, 0,0,0, MA,      8,  0, 0, 0);
        add(1,0,1,1,16'hAB00, 0,0,1, MS|MD,   0,  2, 16'hAB00, 0);
        add(1,0,1,1,16'hAB00, 1,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,1,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0010, 0,0,0, MA,      8,  0, 0, 0);
        add(1,0,1,1,16'h00CD, 0,0,1, MS|MD,   0,  1, 16'h00CD, 0);
        add(1,0,1,1,16'h00CD, 1,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0010, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 1,1,0, MO,      0,  0, 0, 16'hABCD);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // Out of window: no reply, no write.
        add(1,0,0,0,16'h0800, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0800, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0800, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,1,0,16'hFFFF, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // DATIO at 0x0020: read, then write 0x5555 in the same SYNC.
        add(1,0,0,0,16'h0020, 0,0,0, MA,      16, 0, 0, 0);
        add(1,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 1,1,0, MO,      0,  0, 0, 16'h0000);
        add(1,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,1,0,16'h5555, 0,0,1, MS|MD,   0,  3, 16'h5555, 0);
        add(1,0,1,0,16'h5555, 1,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,0,0,16'h0020, 0,0,0, MA,      16, 0, 0, 0);
        add(1,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 1,1,0, MO,      0,  0, 0, 16'h5555);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // DIN and DOUT together: read first, write only after the read completes.
        add(1,0,0,0,16'h0020, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,1,0,16'hAAAA, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,1,0,16'hAAAA, 1,1,0, MO,      0,  0, 0, 16'h5555);
        add(1,0,1,0,16'hAAAA, 0,0,0, 0,       0,  0, 0, 0);
        add(1,0,1,0,16'hAAAA, 0,0,1, MS|MD,   0,  3, 16'hAAAA, 0);
        add(1,0,1,0,16'hAAAA, 1,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // SYNC dropped while in RD.
        add(1,0,0,0,16'h0020, 0,0,0, 0,       0,  0, 0, 0);
        add(1,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,1,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);
        // Word write at odd address writes the full word.
        add(1,0,0,0,16'h0021, 0,0,0, MA,      16, 0, 0, 0);
        add(1,0,1,0,16'h7777, 0,0,1, MA|MS|MD,16, 3, 16'h7777, 0);
        add(1,0,1,0,16'h7777, 1,0,0, 0,       0,  0, 0, 0);
        add(0,0,0,0,16'h0000, 0,0,0, 0,       0,  0, 0, 0);

        // Asynchronous reset values before any clock edge.
        drive(0, 0, 0, 0, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("rst_ad_out",   ad_out,          16'h0000);
        check("rst_ad_oe",    {15'b0, ad_oe},  16'h0000);
        check("rst_rply",     {15'b0, rply},   16'h0000);
        check("rst_ram_addr", {6'b0, ram_addr},16'h0000);
        check("rst_ram_sel",  {14'b0, ram_sel},16'h0000);
        check("rst_ram_di",   ram_di,          16'h0000);
        check("rst_ram_wr",   {15'b0, ram_wr}, 16'h0000);
        repeat (3) step();
        reset_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].sy, vq[i].dn, vq[i].dt, vq[i].wt, vq[i].ad);
            step();
            check($sformatf("row%0d_rply", i), {15'b0, rply},   {15'b0, vq[i].rp});
            check($sformatf("row%0d_oe", i),   {15'b0, ad_oe},  {15'b0, vq[i].oe});
            check($sformatf("row%0d_wr", i),   {15'b0, ram_wr}, {15'b0, vq[i].wr});
            if (vq[i].cm[3]) check($sformatf("row%0d_addr", i), {6'b0, ram_addr}, {6'b0, vq[i].ea});
            if (vq[i].cm[2]) check($sformatf("row%0d_sel", i), {14'b0, ram_sel}, {14'b0, vq[i].es});
            if (vq[i].cm[1]) check($sformatf("row%0d_di", i), ram_di, vq[i].ed);
            if (vq[i].cm[0]) check($sformatf("row%0d_adout", i), ad_out, vq[i].eo);
        end

        // Reset asserted while RAM_WR is high clears it without a clock edge.
        drive(1, 0, 0, 0, 16'h0030);
        step();
        drive(1, 0, 1, 0, 16'h4321);
        step();
        check("wr_before_reset", {15'b0, ram_wr}, 16'h0001);
        reset_n = 1'b0;
        #1;
        check("reset_wr_async",   {15'b0, ram_wr},  16'h0000);
        check("reset_addr_async", {6'b0, ram_addr}, 16'h0000);
        check("reset_di_async",   ram_di,           16'h0000);
        check("reset_rply_async", {15'b0, rply},    16'h0000);
        step();
        reset_n = 1'b1;
        // SYNC still high after release: no fresh rise, so the block stays idle.
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_reset_wr%0d", k),   {15'b0, ram_wr}, 16'h0000);
            check($sformatf("post_reset_rply%0d", k), {15'b0, rply},   16'h0000);
        end
        drive(0, 0, 0, 0, 16'h0000);
        step();
        drive(1, 0, 0, 0, 16'h0030);
        step();
        check("fresh_rise_addr", {6'b0, ram_addr}, 16'h0018);
        drive(1, 0, 1, 0, 16'h4321);
        step();
        check("fresh_rise_wr", {15'b0, ram_wr}, 16'h0001);
        check("fresh_rise_di", ram_di, 16'h4321);
        drive(0, 0, 0, 0, 16'h0000);
        step();
        check("abort_wr_drop", {15'b0, ram_wr}, 16'h0000);
        check("abort_wr_rply", {15'b0, rply},   16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qbus_ram_bridge.md
QBUS_RAM_BRIDGE -- requirements
Module: qbus_ram_bridge

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, byte base of the 2 KB RAM window; only bits [15:11] are significant.
REQ-002 CLK  in  1  sole clock; all logic on the rising edge.
REQ-003 RESET_N  in  1  reset, asynchronous, active-low.
REQ-004 AD_IN  in  16  multiplexed bus address/data from the CPU, synchronous to CLK.
REQ-005 SYNC  in  1  bus cycle active, active-high internal polarity.
REQ-006 DIN  in  1  read strobe.
REQ-007 DOUT  in  1  write strobe.
REQ-008 WTBT  in  1  byte-write qualifier, sampled with DOUT.
REQ-009 AD_OUT  out  16  read data to the bus.
REQ-010 AD_OE  out  1  AD_OUT drive enable.
REQ-011 RPLY  out  1  slave reply.
REQ-012 RAM_ADDR  out  10  word address to the RAM.
REQ-013 RAM_SEL  out  2  byte lane select: bit0 low byte, bit1 high byte.
REQ-014 RAM_DI  out  16  write data to the RAM.
REQ-015 RAM_WR  out  1  RAM write strobe.
REQ-016 RAM_DO  in  16  RAM read data, valid one CLK after RAM_ADDR is stable.

Function
REQ-017 States: IDLE, SEL, RD, WR, REPLY, SKIP; all outputs are registered.
REQ-018 IDLE: SYNC rising (SYNC=1, previous-cycle SYNC=0) with AD_IN[15:11]==BASE_ADDR[15:11] -> latch RAM_ADDR=AD_IN[10:1] and A0=AD_IN[0], go to SEL; a SYNC rise outside the window -> SKIP.
REQ-019 SKIP: no outputs asserted; SYNC=0 -> IDLE.
REQ-020 SEL, DIN=1 -> RD; at the next edge, AD_OUT=RAM_DO, AD_OE=1, RPLY=1, go to REPLY, giving RPLY one cycle after DIN is sampled.
REQ-021 SEL, DOUT=1 (DIN=0) -> RAM_DI=AD_IN, RAM_WR=1 for exactly one cycle, go to WR; at the next edge RAM_WR=0, RPLY=1, go to REPLY.
REQ-022 Write lanes: WTBT=0 -> RAM_SEL=2'b11; WTBT=1 and A0=0 -> 2'b01; WTBT=1 and A0=1 -> 2'b10. Byte data occupies its own lane of AD_IN and is not shifted.
REQ-023 Word write with A0=1 writes the full word at RAM_ADDR; no odd-address trap is raised.
REQ-024 DIN and DOUT both high in SEL -> read takes priority; DOUT is ignored until that read completes.
REQ-025 REPLY: hold RPLY (and AD_OE/AD_OUT for a read) until the active strobe is sampled low; at that edge RPLY=0 and AD_OE=0, go to SEL if SYNC=1 (supports DATIO read-then-write), otherwise IDLE.
REQ-026 SYNC sampled low in any state -> next edge RPLY=0, AD_OE=0, state IDLE.
REQ-027 A RAM_WR already issued always completes its single cycle regardless of SYNC.
REQ-028 RAM_ADDR holds its latched value outside cycles; RAM_WR is never high outside WR entry.
REQ-029 Maximum one RAM write per DOUT assertion.

Reset
REQ-030 RESET_N=0 forces state IDLE, and AD_OUT, AD_OE, RPLY, RAM_ADDR, RAM_SEL, RAM_DI and RAM_WR to 0, immediately, without waiting for CLK.
REQ-031 Reset mid-cycle aborts the cycle; after release the block waits for a fresh SYNC rise.

Structure
REQ-032 Shared package qbus_pkg holds the state enumeration, WIN_BITS=11 and RAM_AW=10.
REQ-033 No sub-module; the RAM is instantiated beside this block by the parent.

Verification
REQ-034 Word write then read: SYNC rise with AD_IN=16'h0010, DOUT, WTBT=0, data 16'h1234 -> one-cycle RAM_WR with RAM_ADDR=8, RAM_SEL=11 and RPLY; a following read at 16'h0010 -> AD_OUT=16'h1234 with RPLY one cycle after DIN.
REQ-035 Byte writes: 16'h0011 with WTBT=1 and data 16'hAB00 -> RAM_SEL=10; 16'h0010 with data 16'h00CD -> RAM_SEL=01; a read of 16'h0010 -> 16'hABCD.
REQ-036 Out of window: SYNC rise with AD_IN=16'h0800 and BASE_ADDR=0, then DIN -> RPLY and AD_OE stay 0 throughout the cycle, and RAM_WR is never asserted.
REQ-037 DATIO: one SYNC, DIN -> RPLY, DIN low, then DOUT with 16'h5555 -> two RPLY pulses and one write of 16'h5555.
REQ-038 Abort: SYNC drops while in RD -> RPLY and AD_OE remain 0; RESET_N low during WR -> RAM_WR low immediately and state IDLE.
